// File: rtl/mips_mem_pkg.sv
// Shared types, widths and address helpers for the MIPS data-memory responder.
package mips_mem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Request fields captured at accept; the only copy used after the handshake.
   typedef struct packed {
      logic              we;
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] wd;
      logic [BE_W-1:0]   be;
   } mem_req_t;

   function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] a,
                                                    input int unsigned       idx_w);
      return (a >> 2) & ((WORD_W'(1) << idx_w) - WORD_W'(1));
   endfunction

   function automatic logic in_range(input logic [WORD_W-1:0] a,
                                     input int unsigned       idx_w);
      return (a >> (idx_w + 2)) == '0;
   endfunction

   function automatic logic addr_bad(input logic [WORD_W-1:0] a,
                                     input int unsigned       idx_w);
      return (a[1:0] != 2'b00) || !in_range(a, idx_w);
   endfunction

endpackage

// File: rtl/mips_data_memory_responder_if.sv
// Data-memory port between the CPU (master) and the memory responder (slave).
interface mips_data_memory_responder_if;
   import mips_mem_pkg::*;

   logic              req;
   logic              we;
   logic [WORD_W-1:0] a;
   logic [WORD_W-1:0] wd;
   logic [BE_W-1:0]   be;
   logic [WORD_W-1:0] rd;
   logic              ready;
   logic              err;

   modport master (output req, we, a, wd, be, input rd, ready, err);
   modport slave  (input req, we, a, wd, be, output rd, ready, err);

endinterface

// File: rtl/mips_byte_ram.sv
// Single-port RAM with per-byte write enables and a registered read port; no reset.
module mips_byte_ram
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_we,
   input  logic [BE_W-1:0]   i_be,
   input  logic [WORD_W-1:0] i_wd,
   output logic [WORD_W-1:0] o_q
);

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wd[8*b +: 8];
         end
      end
      r_q <= r_mem[i_addr];
   end

   assign o_q = r_q;

endmodule

// File: rtl/mips_data_memory_responder.sv
// Multi-cycle data-memory target: accepts one word access, waits WAIT_STATES cycles,
// then strobes ready with load data or commits the store; bad addresses raise err.
module mips_data_memory_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   mips_data_memory_responder_if.slave   bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   mem_req_t           r_req;
   logic               r_bad;
   logic               r_ready;
   logic               r_err;
   logic               r_rd_en;

   mem_req_t           w_req;
   logic               w_bad;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   w_addr;
   logic               w_wr_en;
   logic [WORD_W-1:0]  w_ram_q;

   always_comb begin
      w_req    = '0;
      w_req.we = bus.we;
      w_req.a  = bus.a;
      w_req.wd = bus.wd;
      w_req.be = bus.be;
   end

   assign w_bad   = addr_bad(bus.a, IDX_W);
   assign w_idx   = IDX_W'(word_index(r_req.a, IDX_W));
   // In IDLE the RAM reads the incoming address so zero-wait loads have data in RESP.
   assign w_addr  = (r_state == IDLE) ? IDX_W'(word_index(bus.a, IDX_W)) : w_idx;
   assign w_wr_en = (r_state == RESP) && r_req.we && !r_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_req   <= '0;
         r_bad   <= 1'b0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_rd_en <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_rd_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req) begin
                  r_req <= w_req;
                  r_bad <= w_bad;
                  if (WAIT_STATES == 0) begin
                     r_state <= RESP;
                     r_ready <= 1'b1;
                     r_err   <= w_bad;
                     r_rd_en <= !bus.we && !w_bad;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_W'(WAIT_STATES) - CNT_W'(1);
                  end
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= RESP;
                  r_ready <= 1'b1;
                  r_err   <= r_bad;
                  r_rd_en <= !r_req.we && !r_bad;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   mips_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk    (clk),
      .i_addr (w_addr),
      .i_we   (w_wr_en),
      .i_be   (r_req.be),
      .i_wd   (r_req.wd),
      .o_q    (w_ram_q)
   );

   assign bus.ready = r_ready;
   assign bus.err   = r_err;
   assign bus.rd    = r_rd_en ? w_ram_q : '0;

endmodule

// File: tb/tb_mips_data_memory_responder.sv
// Directed bench: default-latency responder plus a zero-wait-state instance.
module tb_mips_data_memory_responder;
   import mips_mem_pkg::*;

   localparam int unsigned WS = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   mips_data_memory_responder_if bus2 ();
   mips_data_memory_responder_if bus0 ();

   mips_data_memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(WS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   mips_data_memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Returns #1 after the accept edge.
   task automatic start(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be);
      @(posedge clk); #1;
      bus2.req = 1'b1; bus2.we = we; bus2.a = a; bus2.wd = wd; bus2.be = be;
      @(posedge clk); #1;
   endtask

   task automatic finish(input string tag, input logic exp_err, input logic chk_rd,
                         input logic [31:0] exp_rd);
      int n = 1;
      while (bus2.ready !== 1'b1 && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      bus2.req = 1'b0;
      check({tag, "_lat"}, 32'(n), 32'(WS + 1));
      check({tag, "_err"}, 32'(bus2.err), 32'(exp_err));
      if (chk_rd) check({tag, "_rd"}, bus2.rd, exp_rd);
      @(posedge clk); #1;
      check({tag, "_rdy_off"}, 32'(bus2.ready), 32'd0);
   endtask

   task automatic access(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic exp_err,
                         input logic [31:0] exp_rd);
      start(we, a, wd, be);
      finish(tag, exp_err, !we, exp_rd);
   endtask

   logic        z_we  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [31:0] z_a   [5] = '{32'h8, 32'hC, 32'h8, 32'hC, 32'h3};
   logic [31:0] z_wd  [5] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0, 32'h0, 32'h0};
   logic        z_err [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] z_rd  [5] = '{32'h0, 32'h0, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0};

   initial begin
      bus2.req = 1'b0; bus2.we = 1'b0; bus2.a = '0; bus2.wd = '0; bus2.be = '0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.a = '0; bus0.wd = '0; bus0.be = '0;

      #12;
      check("rst_ready", 32'(bus2.ready), 32'd0);
      check("rst_err",   32'(bus2.err),   32'd0);
      check("rst_rd",    bus2.rd,         32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      access("st10",   1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
      access("ld10",   1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF);
      access("st10be", 1'b1, 32'h10, 32'h11223344, 4'h5, 1'b0, 32'h0);
      access("ld10be", 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDE22BE44);

      access("st00",   1'b1, 32'h0,   32'h01020304, 4'hF, 1'b0, 32'h0);
      access("ld13",   1'b0, 32'h13,  32'h0,        4'h0, 1'b1, 32'h0);
      access("st100",  1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
      access("ld00",   1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h01020304);
      access("stbe0",  1'b1, 32'h10,  32'h0,        4'h0, 1'b0, 32'h0);
      access("ldbe0",  1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDE22BE44);

      // Inputs altered while waiting must not affect the accepted access.
      start(1'b1, 32'h24, 32'h13572468, 4'hF);
      bus2.a = 32'h10; bus2.wd = 32'h0; bus2.we = 1'b0; bus2.be = 4'h0;
      finish("chg_st", 1'b0, 1'b0, 32'h0);
      access("ld24",   1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 32'h13572468);
      start(1'b0, 32'h24, 32'h0, 4'h0);
      bus2.we = 1'b1; bus2.a = 32'h10; bus2.wd = 32'hFFFFFFFF; bus2.be = 4'hF;
      finish("chg_ld", 1'b0, 1'b1, 32'h13572468);
      access("ld10b",  1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);

      // Reset while waiting aborts the store.
      access("st20",   1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0);
      start(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      check("wrst_ready", 32'(bus2.ready), 32'd0);
      check("wrst_err",   32'(bus2.err),   32'd0);
      check("wrst_rd",    bus2.rd,         32'd0);
      bus2.req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      access("ld20a",  1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h5A5A5A5A);

      // Reset during the response cycle, before its closing edge, blocks the write.
      start(1'b1, 32'h20, 32'h77777777, 4'hF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rrst_pre", 32'(bus2.ready), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rrst_ready", 32'(bus2.ready), 32'd0);
      bus2.req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      access("ld20b",  1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h5A5A5A5A);

      // Zero wait states with req held high: a response every second cycle.
      @(posedge clk); #1;
      bus0.req = 1'b1; bus0.we = z_we[0]; bus0.a = z_a[0]; bus0.wd = z_wd[0]; bus0.be = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("z%0d_rdy", k), 32'(bus0.ready), 32'd1);
         check($sformatf("z%0d_err", k), 32'(bus0.err),   32'(z_err[k]));
         if (!z_we[k]) check($sformatf("z%0d_rd", k), bus0.rd, z_rd[k]);
         if (k < 4) begin
            bus0.we = z_we[k+1]; bus0.a = z_a[k+1]; bus0.wd = z_wd[k+1];
         end else begin
            bus0.req = 1'b0;
         end
         @(posedge clk); #1;
         check($sformatf("z%0d_gap", k), 32'(bus0.ready), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
